// File: rtl/mem_arbiter_if.sv
// Request/response and RAM bus bundle for the unified-RAM arbiter.
// slave = arbiter side, master = requesters plus RAM side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_err;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_lock;
    logic              ldr_ack;
    logic [DATA_W-1:0] ldr_rdata;
    logic              ldr_err;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_err,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
        output ldr_ack, ldr_rdata, ldr_err,
        output mem_we, mem_a, mem_wd,
        input  mem_rd
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_err,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
        input  ldr_ack, ldr_rdata, ldr_err,
        input  mem_we, mem_a, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the CPU and the loader, round-robin on ties.
// Every access is IDLE -> ACCESS -> RESP; ack pulses in RESP, two cycles after the grant.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              cpu_elig, ldr_elig, grant, grant_ldr;
    logic              last_ldr;
    logic              own_ldr;
    logic [ADDR_W-1:0] addr_q, sel_addr;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q, mis_q;
    logic [DATA_W-1:0] cpu_rdata_q, ldr_rdata_q;
    logic              cpu_err_q, ldr_err_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // The lock only masks CPU eligibility, so an in-flight CPU access finishes.
    always_comb begin
        cpu_elig  = bus.cpu_req & ~bus.ldr_lock;
        ldr_elig  = bus.ldr_req;
        grant     = cpu_elig | ldr_elig;
        grant_ldr = (cpu_elig & ldr_elig) ? ~last_ldr : ldr_elig;
        sel_addr  = grant_ldr ? bus.ldr_addr : bus.cpu_addr;
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        bus.mem_a     = addr_q;
        bus.mem_wd    = wdata_q;
        bus.mem_we    = (state == ACCESS) & we_q & ~mis_q & ~reset;
        bus.cpu_ack   = (state == RESP) & ~own_ldr & ~reset;
        bus.ldr_ack   = (state == RESP) &  own_ldr & ~reset;
        bus.cpu_rdata = cpu_rdata_q;
        bus.ldr_rdata = ldr_rdata_q;
        bus.cpu_err   = cpu_err_q;
        bus.ldr_err   = ldr_err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_ldr    <= 1'b1;
            own_ldr     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            mis_q       <= 1'b0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
            cpu_err_q   <= 1'b0;
            ldr_err_q   <= 1'b0;
        end else begin
            if (state == IDLE && grant) begin
                own_ldr  <= grant_ldr;
                last_ldr <= grant_ldr;
                addr_q   <= sel_addr;
                wdata_q  <= grant_ldr ? bus.ldr_wdata : bus.cpu_wdata;
                we_q     <= grant_ldr ? bus.ldr_we    : bus.cpu_we;
                mis_q    <= (sel_addr[1:0] != 2'b00);
            end
            // Read data is captured even for writes: the requester sees the pre-write word.
            if (state == ACCESS) begin
                if (own_ldr) begin
                    ldr_rdata_q <= bus.mem_rd;
                    ldr_err_q   <= mis_q;
                end else begin
                    cpu_rdata_q <= bus.mem_rd;
                    cpu_err_q   <= mis_q;
                end
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified instruction/data RAM between two requesters: the multi-cycle CPU (fetch/load/store) and a program loader/debug port.
- Each requester uses a req/ack handshake.
- A fixed 3-state FSM sequences each RAM access; ties are resolved round-robin.
- The loader can lock out the CPU to download a program image before execution.

Parameters:
- ADDR_W, 32, byte-address width of requester and RAM address buses
- DATA_W, 32, data word width

Ports:
- clk  input  1  system clock, all state on posedge
- reset  input  1  synchronous, active-high reset
- cpu_req  input  1  CPU access request; held with stable fields until cpu_ack
- cpu_we  input  1  CPU write (1) / read (0)
- cpu_addr  input  ADDR_W  CPU byte address, word-aligned
- cpu_wdata  input  DATA_W  CPU write data
- cpu_ack  output  1  one-cycle completion pulse to CPU
- cpu_rdata  output  DATA_W  read data, valid while cpu_ack=1
- cpu_err  output  1  misaligned-access flag, valid while cpu_ack=1
- ldr_req  input  1  loader access request
- ldr_we  input  1  loader write/read
- ldr_addr  input  ADDR_W  loader byte address
- ldr_wdata  input  DATA_W  loader write data
- ldr_lock  input  1  when 1, CPU requests are never granted
- ldr_ack  output  1  one-cycle completion pulse to loader
- ldr_rdata  output  DATA_W  loader read data, valid while ldr_ack=1
- ldr_err  output  1  loader misaligned flag, valid while ldr_ack=1
- mem_we  output  1  RAM write enable
- mem_a  output  ADDR_W  RAM address
- mem_wd  output  DATA_W  RAM write data
- mem_rd  input  DATA_W  RAM read data, combinational from mem_a
- busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset values: state=IDLE; last_grant=LDR, so the CPU wins the first tie. cpu_ack, ldr_ack, cpu_err, ldr_err, busy and mem_we are 0. cpu_rdata, ldr_rdata, and the latched addr/wdata/we are 0, so mem_a=0 and mem_wd=0.
- FSM IDLE -> ACCESS -> RESP -> IDLE. Each access takes exactly 3 cycles, giving a throughput of one access per 3 cycles.
- IDLE (cycle N):
  - Eligible requesters are ldr_req, plus cpu_req only if ldr_lock=0.
  - One eligible requester: grant it.
  - Both eligible: grant the one not equal to last_grant.
  - On a grant: latch addr/we/wdata/owner, set misalign=(addr[1:0]!=0), update last_grant, go to ACCESS.
  - No eligible requester: stay in IDLE.
- ACCESS (N+1):
  - mem_a=latched addr and mem_wd=latched wdata.
  - mem_we = latched we & ~misalign & ~reset. Reset gates the write so an access aborted by reset never commits.
  - At the clock edge, capture mem_rd into the owner's rdata register, and set the owner's err=misalign.
- RESP (N+2):
  - Owner's ack=1 with rdata/err valid; the non-owner's ack stays 0. mem_we=0.
  - Next state is IDLE.
- rdata and err registers hold their value after ack until the next completion for that requester. On writes, rdata is updated with the pre-write mem_rd value.
- Outside ACCESS: mem_we=0; mem_a and mem_wd hold the latched values.
- Handshake rules:
  - A requester drops req, or presents a new request, in the cycle after ack.
  - Changes to fields after the grant are ignored.
  - A req still high in the IDLE after RESP is treated as a new request.
- Misaligned access: no RAM write; the read still completes. ack=1 and err=1 in RESP.
- ldr_lock rising while a CPU access is in ACCESS or RESP: that access completes normally; the lock applies from the next IDLE.
- Reset in any state: state returns to IDLE at the edge, and any pending ack is suppressed.
- Addresses pass through unchanged; word indexing is the RAM's responsibility.

Test Plan:
- Loader writes 0x00500113 to 0x0 (ldr_we=1), then the CPU reads 0x0 -> ldr_ack at N+2, then cpu_ack with cpu_rdata=0x00500113 exactly 2 cycles after its IDLE grant. mem_we is high for exactly 1 cycle.
- After reset, cpu_req and ldr_req rise in the same cycle and both stay asserted -> CPU served first (cpu_ack at N+2), loader next (ldr_ack at N+5), then CPU again (N+8): strict alternation.
- ldr_lock=1 with cpu_req held high for 20 cycles and no loader request -> cpu_ack never asserts and busy stays 0. Dropping ldr_lock at cycle T -> cpu_ack at T+2.
- CPU write of 0xDEADBEEF to 0x06 -> cpu_ack=1, cpu_err=1, mem_we never asserts, and a follow-up read of 0x04 returns its prior value.
- Loader write of 0x0221A023 to 0x50 with reset asserted during ACCESS -> mem_we=0 that cycle, no ldr_ack, state returns to IDLE, and a later read of 0x50 returns the old contents.
- Back-to-back CPU reads of 0x00, 0x04, 0x08 with req kept high -> cpu_ack at N+2, N+5, N+8 with the correct data; busy low only in the IDLE cycles.
